// File: rtl/mixer_pkg.sv
// Shared definitions for the multiplier-sharing scheduler slice.
//   state_t : scheduler FSM states (IDLE -> ISSUE -> WAIT_RESULT -> DELIVER)
//   CNT_W   : width of the saturating overflow statistics counter
package mixer_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESULT,
    ST_DELIVER
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin winner selection for the multiplier-sharing scheduler.
// Searches upward from (last_grant + 1) mod NR_OF_REQ_P and reports the
// first requester with its req bit set.
// Ports:
//   req        : per-requester request vector
//   last_grant : index of the requester served most recently
//   grant_id   : index of the winning requester (valid when any = 1)
//   any        : at least one request is pending
module rr_grant #(
  parameter int NR_OF_REQ_P = 4
) (
  input  logic [NR_OF_REQ_P-1:0]         req,
  input  logic [$clog2(NR_OF_REQ_P)-1:0] last_grant,
  output logic [$clog2(NR_OF_REQ_P)-1:0] grant_id,
  output logic                           any
);

  localparam int ID_W = $clog2(NR_OF_REQ_P);

  logic [ID_W-1:0] idx;

  // Offset 1 is checked first, so the previous winner has lowest priority.
  always_comb begin
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= NR_OF_REQ_P; i++) begin
      idx = ID_W'((32'(last_grant) + i) % NR_OF_REQ_P);
      if (!any && req[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/mul_share_scheduler.sv
// Time-shares one multiplier between NR_OF_REQ_P requesters, one transaction
// in flight at a time, with round-robin arbitration.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : per-requester request handshake
//                                     (req_ready is the only combinational output)
//   req_multiplicand/req_multiplier : per-requester signed operands
//   mul_ing_*                       : multiplier ingress (valid/ready + operands)
//   mul_egr_*                       : multiplier egress, no backpressure
//   rsp_valid/rsp_ready             : per-requester response handshake
//   rsp_product/rsp_overflow        : shared response data bus
//   sr_busy, sr_grant_id            : status (not idle, current grant)
//   sr_overflow_cnt                 : saturating count of overflowing responses
//   sr_spurious                     : sticky flag, egress valid seen outside WAIT_RESULT
// Build option:
//   MUL_SHARE_SATURATE_EN : replace overflowing products with the signed
//                           max/min chosen by the operand signs.
module mul_share_scheduler
  import mixer_pkg::*;
#(
  parameter int NR_OF_REQ_P = 4,
  parameter int N_BITS_P    = 24
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NR_OF_REQ_P-1:0]                req_valid,
  output logic [NR_OF_REQ_P-1:0]                req_ready,
  input  logic [NR_OF_REQ_P-1:0][N_BITS_P-1:0]  req_multiplicand,
  input  logic [NR_OF_REQ_P-1:0][N_BITS_P-1:0]  req_multiplier,
  output logic                                  mul_ing_valid,
  input  logic                                  mul_ing_ready,
  output logic [N_BITS_P-1:0]                   mul_ing_multiplicand,
  output logic [N_BITS_P-1:0]                   mul_ing_multiplier,
  input  logic                                  mul_egr_valid,
  input  logic [N_BITS_P-1:0]                   mul_egr_product,
  input  logic                                  mul_egr_overflow,
  output logic [NR_OF_REQ_P-1:0]                rsp_valid,
  input  logic [NR_OF_REQ_P-1:0]                rsp_ready,
  output logic [N_BITS_P-1:0]                   rsp_product,
  output logic                                  rsp_overflow,
  output logic                                  sr_busy,
  output logic [$clog2(NR_OF_REQ_P)-1:0]        sr_grant_id,
  output logic [CNT_W-1:0]                      sr_overflow_cnt,
  output logic                                  sr_spurious
);

  localparam int ID_W = $clog2(NR_OF_REQ_P);

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] rr_id;
  logic            rr_any;
  logic            req_hs, ing_hs, egr_take, rsp_hs;
  logic [N_BITS_P-1:0] prod_sel;

  rr_grant #(
    .NR_OF_REQ_P(NR_OF_REQ_P)
  ) u_rr_grant (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant_id  (rr_id),
    .any       (rr_any)
  );

  // Next-state and handshake decode. req_ready is driven here so the winner
  // sees ready in the same cycle its valid is high.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    req_hs    = 1'b0;
    ing_hs    = 1'b0;
    egr_take  = 1'b0;
    rsp_hs    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rr_any) begin
          req_ready[rr_id] = 1'b1;
          req_hs           = 1'b1;
          state_nxt        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mul_ing_ready) begin
          ing_hs    = 1'b1;
          state_nxt = ST_WAIT_RESULT;
        end
      end
      ST_WAIT_RESULT: begin
        if (mul_egr_valid) begin
          egr_take  = 1'b1;
          state_nxt = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (rsp_ready[sr_grant_id]) begin
          rsp_hs    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef MUL_SHARE_SATURATE_EN
  localparam logic [N_BITS_P-1:0] SAT_MAX = {1'b0, {(N_BITS_P-1){1'b1}}};
  localparam logic [N_BITS_P-1:0] SAT_MIN = {1'b1, {(N_BITS_P-1){1'b0}}};

  // Operand signs differ -> true product is negative -> clamp to minimum.
  logic sign_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_diff <= 1'b0;
    end else if (req_hs) begin
      sign_diff <= req_multiplicand[rr_id][N_BITS_P-1] ^ req_multiplier[rr_id][N_BITS_P-1];
    end
  end

  always_comb begin
    prod_sel = mul_egr_product;
    if (mul_egr_overflow) begin
      prod_sel = sign_diff ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    prod_sel = mul_egr_product;
  end
`endif

  // Registered outputs are loaded from the next state so that valids and
  // busy change in the same cycle as the FSM itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      last_grant           <= ID_W'(NR_OF_REQ_P - 1);
      sr_grant_id          <= '0;
      mul_ing_valid        <= 1'b0;
      mul_ing_multiplicand <= '0;
      mul_ing_multiplier   <= '0;
      rsp_valid            <= '0;
      rsp_product          <= '0;
      rsp_overflow         <= 1'b0;
      sr_busy              <= 1'b0;
      sr_overflow_cnt      <= '0;
      sr_spurious          <= 1'b0;
    end else begin
      state         <= state_nxt;
      sr_busy       <= (state_nxt != ST_IDLE);
      mul_ing_valid <= (state_nxt == ST_ISSUE);

      rsp_valid <= '0;
      if (state_nxt == ST_DELIVER) begin
        rsp_valid[sr_grant_id] <= 1'b1;
      end

      if (req_hs) begin
        sr_grant_id          <= rr_id;
        mul_ing_multiplicand <= req_multiplicand[rr_id];
        mul_ing_multiplier   <= req_multiplier[rr_id];
      end

      if (egr_take) begin
        rsp_product  <= prod_sel;
        rsp_overflow <= mul_egr_overflow;
      end

      if (rsp_hs) begin
        last_grant <= sr_grant_id;
        if (rsp_overflow && (sr_overflow_cnt != '1)) begin
          sr_overflow_cnt <= sr_overflow_cnt + CNT_W'(1);
        end
      end

      if (mul_egr_valid && (state != ST_WAIT_RESULT)) begin
        sr_spurious <= 1'b1;
      end
    end
  end

  // ing_hs is kept for readability of the decode; the FSM already advances on it.
  logic unused_ing_hs;
  always_comb begin
    unused_ing_hs = ing_hs;
  end

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Self-checking bench for mul_share_scheduler (4 requesters, 24-bit Q11 operands,
// 2-cycle multiplier model). A transaction-level reference model is compared
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_mul_share_scheduler;

  localparam int NR  = 4;
  localparam int NB  = 24;
  localparam int IDW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_ready;
  logic [NR-1:0][NB-1:0]  req_multiplicand, req_multiplier;
  logic                   mul_ing_valid, mul_ing_ready;
  logic [NB-1:0]          mul_ing_multiplicand, mul_ing_multiplier;
  logic                   mul_egr_valid;
  logic [NB-1:0]          mul_egr_product;
  logic                   mul_egr_overflow;
  logic [NR-1:0]          rsp_valid, rsp_ready;
  logic [NB-1:0]          rsp_product;
  logic                   rsp_overflow;
  logic                   sr_busy;
  logic [IDW-1:0]         sr_grant_id;
  logic [15:0]            sr_overflow_cnt;
  logic                   sr_spurious;
  logic                   spur_pulse;

  mul_share_scheduler #(
    .NR_OF_REQ_P(NR),
    .N_BITS_P   (NB)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_multiplicand    (req_multiplicand),
    .req_multiplier      (req_multiplier),
    .mul_ing_valid       (mul_ing_valid),
    .mul_ing_ready       (mul_ing_ready),
    .mul_ing_multiplicand(mul_ing_multiplicand),
    .mul_ing_multiplier  (mul_ing_multiplier),
    .mul_egr_valid       (mul_egr_valid),
    .mul_egr_product     (mul_egr_product),
    .mul_egr_overflow    (mul_egr_overflow),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_product         (rsp_product),
    .rsp_overflow        (rsp_overflow),
    .sr_busy             (sr_busy),
    .sr_grant_id         (sr_grant_id),
    .sr_overflow_cnt     (sr_overflow_cnt),
    .sr_spurious         (sr_spurious)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier model: Q11 signed, 2-cycle latency ----------------
  function automatic logic [NB:0] mul_q11(input logic [NB-1:0] a, input logic [NB-1:0] b);
    longint sa, sb, sh;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = (sa * sb) >>> 11;
    ovf = (sh > 64'sd8388607) || (sh < -64'sd8388608);
    return {ovf, sh[NB-1:0]};
  endfunction

  logic          p1_v, p2_v, p1_o, p2_o;
  logic [NB-1:0] p1_p, p2_p;
  logic [NB:0]   mres;

  always_comb mres = mul_q11(mul_ing_multiplicand, mul_ing_multiplier);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_o <= 1'b0; p2_o <= 1'b0;
      p1_p <= '0;   p2_p <= '0;
    end else begin
      p1_v <= mul_ing_valid && mul_ing_ready;
      p1_o <= mres[NB];
      p1_p <= mres[NB-1:0];
      p2_v <= p1_v;
      p2_o <= p1_o;
      p2_p <= p1_p;
    end
  end

  assign mul_egr_valid    = p2_v | spur_pulse;
  assign mul_egr_product  = p2_p;
  assign mul_egr_overflow = p2_o;

  // ---------------- transaction-level reference model ----------------
  bit             m_act, m_iss, m_done, m_spur;
  int             m_owner, m_last, m_cnt;
  logic [NB-1:0]  m_a, m_b, m_prod;
  logic           m_ovf;
  logic [IDW-1:0] m_gid;

  function automatic int rr_pick(input int last, input logic [NR-1:0] rq);
    for (int k = 1; k <= NR; k++) begin
      if (rq[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NB-1:0] exp_prod(input logic [NB-1:0] raw, input logic ovf,
                                             input logic [NB-1:0] a, input logic [NB-1:0] b);
`ifdef MUL_SHARE_SATURATE_EN
    if (ovf) return (a[NB-1] == b[NB-1]) ? 24'h7FFFFF : 24'h800000;
`endif
    return raw;
  endfunction

  task automatic model_reset();
    m_act = 0; m_iss = 0; m_done = 0; m_spur = 0;
    m_owner = 0; m_last = NR - 1; m_cnt = 0;
    m_a = '0; m_b = '0; m_prod = '0; m_ovf = 1'b0; m_gid = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int            w;
    logic [NR-1:0] e_rdy, e_rv;
    if (!rst_n) model_reset();
    w     = rr_pick(m_last, req_valid);
    e_rdy = '0;
    if (!m_act && w >= 0) e_rdy[w] = 1'b1;
    e_rv = '0;
    if (m_act && m_done) e_rv[m_owner] = 1'b1;

    check("req_ready",     req_ready,            e_rdy);
    check("ing_valid",     mul_ing_valid,        m_act && !m_iss);
    check("ing_mcand",     mul_ing_multiplicand, m_a);
    check("ing_mplier",    mul_ing_multiplier,   m_b);
    check("rsp_valid",     rsp_valid,            e_rv);
    check("rsp_product",   rsp_product,          m_prod);
    check("rsp_overflow",  rsp_overflow,         m_ovf);
    check("sr_busy",       sr_busy,              m_act);
    check("sr_grant_id",   sr_grant_id,          m_gid);
    check("sr_ovf_cnt",    sr_overflow_cnt,      m_cnt);
    check("sr_spurious",   sr_spurious,          m_spur);

    if (rst_n) begin
      if (mul_egr_valid && !(m_act && m_iss && !m_done)) m_spur = 1;
      if (!m_act) begin
        if (w >= 0) begin
          m_act = 1; m_iss = 0; m_done = 0; m_owner = w;
          m_gid = w[IDW-1:0];
          m_a   = req_multiplicand[w];
          m_b   = req_multiplier[w];
        end
      end else if (!m_iss) begin
        if (mul_ing_ready) m_iss = 1;
      end else if (!m_done) begin
        if (mul_egr_valid) begin
          m_done = 1;
          m_ovf  = mul_egr_overflow;
          m_prod = exp_prod(mul_egr_product, mul_egr_overflow, m_a, m_b);
        end
      end else if (rsp_ready[m_owner]) begin
        m_act  = 0;
        m_last = m_owner;
        if (m_ovf && m_cnt < 65535) m_cnt++;
      end
    end
  end

  // ---------------- event monitor ----------------
  int             cyc = 0;
  int             grant_q[$];
  int             hs_cyc_q[$];
  int             rsp_cyc_q[$];
  logic [NB-1:0]  rsp_prod_q[$];
  int             ing_hs_cnt = 0;
  int             rise_cnt = 0, rise_cyc = 0;
  logic [NR-1:0]  rise_vec, prev_rv = '0;
  logic [NB-1:0]  rise_prod;
  logic           rise_ovf;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          grant_q.push_back(k);
          hs_cyc_q.push_back(cyc);
        end
      end
      if (mul_ing_valid && mul_ing_ready) ing_hs_cnt++;
      if ((rsp_valid & rsp_ready) != '0) begin
        rsp_cyc_q.push_back(cyc);
        rsp_prod_q.push_back(rsp_product);
      end
      if (rsp_valid != '0 && prev_rv == '0) begin
        rise_cnt++;
        rise_cyc  = cyc;
        rise_vec  = rsp_valid;
        rise_prod = rsp_product;
        rise_ovf  = rsp_overflow;
      end
    end
    prev_rv = rsp_valid;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input string tag);
    for (int b = 0; b < 200 && grant_q.size() < n; b++) step();
    check(tag, grant_q.size(), n);
  endtask

  task automatic wait_rsps(input int n, input string tag);
    for (int b = 0; b < 200 && rsp_cyc_q.size() < n; b++) step();
    check(tag, rsp_cyc_q.size(), n);
  endtask

  task automatic wait_rise(input int n, input string tag);
    for (int b = 0; b < 200 && rise_cnt < n; b++) step();
    check(tag, rise_cnt, n);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    req_valid = '0; req_multiplicand = '0; req_multiplier = '0;
    mul_ing_ready = 1'b0; rsp_ready = '0; spur_pulse = 1'b0;
    repeat (3) step();
    check("reset_busy",  sr_busy,         1'b0);
    check("reset_rspv",  rsp_valid,       4'b0000);
    check("reset_cnt",   sr_overflow_cnt, 16'h0000);
    rst_n = 1'b1;
    step();

    // All four requesters continuously valid: service 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NR; i++) begin
      req_multiplicand[i] = 24'((i + 1) * 2048);
      req_multiplier[i]   = 24'((i + 2) * 2048);
    end
    mul_ing_ready = 1'b1;
    rsp_ready     = '1;
    req_valid     = '1;
    wait_grants(8, "rr_grants_8");
    req_valid = '0;
    wait_rsps(8, "rr_rsps_8");
    for (int i = 0; i < 8; i++) check("rr_order", grant_q[i], i % NR);
    check("rr_prod_req1", rsp_prod_q[1], 24'h003000);

    // Requester 2: 1.0 x 2.0 in Q11, latency 4 from req handshake.
    rsp_ready = '0;
    req_multiplicand[2] = 24'h000800;
    req_multiplier[2]   = 24'h001000;
    req_valid = 4'b0100;
    wait_grants(9, "q11_grant");
    req_valid = '0;
    wait_rise(9, "q11_rise");
    check("q11_grant_id", grant_q[8], 2);
    check("q11_latency",  rise_cyc - hs_cyc_q[8], 4);
    check("q11_vec",      rise_vec, 4'b0100);
    check("q11_product",  rise_prod, 24'h001000);
    check("q11_ovf",      rise_ovf, 1'b0);
    rsp_ready = 4'b0100;
    wait_rsps(9, "q11_rsp");
    rsp_ready = '1;

    // Ingress stall for 5 cycles: operands stable, one handshake.
    mul_ing_ready = 1'b0;
    req_multiplicand[0] = 24'h001800;
    req_multiplier[0]   = 24'hFFF800;
    req_valid = 4'b0001;
    wait_grants(10, "stall_grant");
    req_valid = '0;
    base = ing_hs_cnt;
    repeat (5) begin
      check("stall_ing_valid", mul_ing_valid, 1'b1);
      check("stall_mcand",     mul_ing_multiplicand, 24'h001800);
      check("stall_mplier",    mul_ing_multiplier,   24'hFFF800);
      step();
    end
    mul_ing_ready = 1'b1;
    wait_rsps(10, "stall_rsp");
    check("stall_ing_hs_count", ing_hs_cnt - base, 1);
    check("stall_product", rsp_prod_q[9], 24'hFFE800);

    // Positive x negative overflow.
    rsp_ready = '0;
    req_multiplicand[1] = 24'h400000;
    req_multiplier[1]   = 24'hC00000;
    req_valid = 4'b0010;
    wait_grants(11, "ovf_grant");
    req_valid = '0;
    wait_rise(11, "ovf_rise");
`ifdef MUL_SHARE_SATURATE_EN
    check("ovf_product", rise_prod, 24'h800000);
`else
    check("ovf_product", rise_prod, 24'h000000);
`endif
    check("ovf_flag", rise_ovf, 1'b1);
    rsp_ready = '1;
    wait_rsps(11, "ovf_rsp");
    step();
    check("ovf_cnt", sr_overflow_cnt, 16'h0001);

    // Response backpressure on requester 1 blocks requester 3; other rsp_ready bits ignored.
    rsp_ready = 4'b1101;
    req_multiplicand[1] = 24'h000800;
    req_multiplier[1]   = 24'h000800;
    req_multiplicand[3] = 24'h000C00;
    req_multiplier[3]   = 24'h001000;
    req_valid = 4'b0010;
    wait_grants(12, "bp_grant1");
    req_valid = 4'b1000;
    wait_rise(12, "bp_rise1");
    repeat (10) begin
      check("bp_req_ready3", req_ready[3], 1'b0);
      check("bp_rsp_valid",  rsp_valid, 4'b0010);
      step();
    end
    rsp_ready = '1;
    wait_rsps(12, "bp_rsp1");
    wait_grants(13, "bp_grant3");
    check("bp_next_grant", grant_q[12], 3);
    check("bp_order", hs_cyc_q[12] > rsp_cyc_q[11], 1'b1);
    req_valid = '0;
    wait_rsps(13, "bp_rsp3");

    // Spurious egress in IDLE, then reset during WAIT_RESULT.
    spur_pulse = 1'b1;
    step();
    spur_pulse = 1'b0;
    check("spurious_set", sr_spurious, 1'b1);
    rsp_ready = '0;
    req_valid = 4'b0001;
    wait_grants(14, "rst_grant");
    req_valid = '0;
    step();
    check("rst_pre_busy", sr_busy, 1'b1);
    check("rst_pre_ingv", mul_ing_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", sr_busy, 1'b0);
    check("rst_async_spur", sr_spurious, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) begin
      step();
      check("rst_no_rsp", rsp_valid, 4'b0000);
    end
    check("rst_ingv",   mul_ing_valid,   1'b0);
    check("rst_prod",   rsp_product,     24'h000000);
    check("rst_grant",  sr_grant_id,     2'd0);
    check("rst_cnt",    sr_overflow_cnt, 16'h0000);
    check("rst_spur",   sr_spurious,     1'b0);
    check("rst_mcand",  mul_ing_multiplicand, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_scheduler.md
MUL_SHARE_SCHEDULER -- requirements
Module: mul_share_scheduler

Interface
REQ-001 SHALL have parameter NR_OF_REQ_P, default 4, number of requesters sharing one multiplier (2..16).
REQ-002 SHALL have parameter N_BITS_P, default 24, operand/product width.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports req_valid / req_ready, input / output, NR_OF_REQ_P each, per-requester handshake.
REQ-006 SHALL have ports req_multiplicand and req_multiplier, input, NR_OF_REQ_P x N_BITS_P each, signed per-requester operands.
REQ-007 SHALL have ports mul_ing_valid / mul_ing_ready, output / input, 1 each, multiplier ingress handshake.
REQ-008 SHALL have ports mul_ing_multiplicand and mul_ing_multiplier, output, N_BITS_P each.
REQ-009 SHALL have ports mul_egr_valid, mul_egr_product and mul_egr_overflow, input, 1 / N_BITS_P / 1, multiplier egress; the multiplier egress has no backpressure.
REQ-010 SHALL have ports rsp_valid / rsp_ready, output / input, NR_OF_REQ_P each, per-requester response handshake.
REQ-011 SHALL have ports rsp_product and rsp_overflow, output, N_BITS_P / 1, shared response bus.
REQ-012 SHALL have ports sr_busy, output, 1; sr_grant_id, output, $clog2(NR_OF_REQ_P); sr_overflow_cnt, output, 16; sr_spurious, output, 1.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT_RESULT -> DELIVER -> IDLE, with one transaction in flight at a time.
REQ-014 In IDLE with any req_valid set, SHALL grant round-robin, searching upward from (last_grant+1) mod NR_OF_REQ_P; last_grant resets to NR_OF_REQ_P-1, so requester 0 wins first.
REQ-015 SHALL drive req_ready combinationally: only req_ready[grant] high, only in IDLE, in the same cycle the winner's req_valid is high; operands and grant id are registered on that handshake.
REQ-016 In ISSUE, SHALL hold mul_ing_valid=1 with the registered operands, stable, until mul_ing_ready; on handshake SHALL go to WAIT_RESULT.
REQ-017 In WAIT_RESULT, on mul_egr_valid SHALL register product and overflow, then go to DELIVER.
REQ-018 mul_egr_valid in any state other than WAIT_RESULT SHALL be ignored and SHALL set sticky sr_spurious (cleared only by reset).
REQ-019 In DELIVER, SHALL assert only rsp_valid[grant], holding rsp_product/rsp_overflow stable until rsp_ready[grant]; SHALL then update last_grant to grant and return to IDLE.
REQ-020 rsp_ready on a non-granted index SHALL have no effect.
REQ-021 Latency: req handshake at cycle T gives mul_ing_valid at T+1; egr_valid at cycle E gives rsp_valid at E+1. Minimum period is 3 + multiplier latency cycles.
REQ-022 sr_overflow_cnt SHALL increment on each delivered response with overflow=1 and SHALL saturate at 0xFFFF.
REQ-023 sr_busy SHALL be 1 in all states except IDLE; sr_grant_id SHALL show the registered grant.
REQ-024 All outputs except req_ready SHALL be registered.

Reset
REQ-025 On rst_n low, SHALL set: FSM=IDLE, all valids and readies 0, data outputs 0, sr_overflow_cnt=0, sr_spurious=0, last_grant=NR_OF_REQ_P-1.
REQ-026 Reset mid-transaction SHALL discard the in-flight result, and no rsp_valid SHALL follow.

Configuration
REQ-027 With MUL_SHARE_SATURATE_EN defined, an overflowing result SHALL be replaced by the signed maximum (0x7FFFFF for N_BITS_P=24) when the operand signs agree, else by the signed minimum (0x800000); rsp_overflow SHALL still be 1.
REQ-028 With MUL_SHARE_SATURATE_EN undefined, SHALL pass mul_egr_product unmodified, and the operand-sign register SHALL be absent.

Structure
REQ-029 SHALL place the FSM state enum and the counter width constant (16) in a shared package, mixer_pkg.
REQ-030 SHALL put the round-robin grant logic in one sub-module, rr_grant (inputs req and last_grant; outputs grant id and any).

Verification
REQ-031 Setup: NR_OF_REQ_P=4, N_BITS_P=24, 2-cycle multiplier model. All four requesters valid at once SHALL be served in order 0,1,2,3; with all continuously re-requesting, service SHALL continue 0,1,...
REQ-032 Requester 2 sends 0x000800 x 0x001000 (Q11). rsp_valid[2] SHALL assert 4 cycles after its req handshake, with product 0x001000 and overflow=0.
REQ-033 Hold mul_ing_ready=0 for 5 cycles. mul_ing_valid and both operands SHALL stay stable throughout; exactly one ingress handshake SHALL occur.
REQ-034 Model forces overflow on a positive x negative pair. With MUL_SHARE_SATURATE_EN: rsp_product=0x800000 and overflow=1. Without it: raw product. sr_overflow_cnt SHALL be 1 in both builds.
REQ-035 Hold rsp_ready[1]=0 for 10 cycles while requester 3 is valid. req_ready[3] SHALL stay 0 until the response to requester 1 is delivered.
REQ-036 Pulse mul_egr_valid while in IDLE, then separately assert rst_n low while in WAIT_RESULT. Expect sr_spurious=1 after the pulse; after reset, no rsp_valid, and all outputs at reset values.
